// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / CGRA offload controller.
// Holds the FSM state encoding, the NOP instruction word and the hardwired zero register.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_CGRA_REQ  = 2'd1,
        ST_CGRA_WAIT = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // All-zero word: a NOP whose control fields are all 0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use hazard compare: flags an ID instruction that reads the register
// still being loaded by the instruction in EX.
module hazard_lu_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_mem_read,
    output logic       lu_hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match  = id_uses_rs && (id_rs_addr == ex_rd_addr);
    assign rt_match  = id_uses_rt && (id_rt_addr == ex_rd_addr);
    // r0 reads are never stale, so a load targeting r0 cannot cause a hazard.
    assign lu_hazard = ex_mem_read && (ex_rd_addr != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and offload controller: drives PC / IF/ID / ID/EX hold, flush and bubble
// controls and sequences the start/done handshake with the CGRA accelerator.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CGRA_TIMEOUT = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_addr_i,
    input  logic [4:0]       id_rt_addr_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             id_cgra_op_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic             branch_taken_i,
    input  logic             cgra_ready_i,
    input  logic             cgra_done_i,
    input  logic             perf_clr_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             cgra_start_o,
    output logic             cgra_timeout_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int            TO_W    = (CGRA_TIMEOUT > 1) ? $clog2(CGRA_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CGRA_TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            to_clr;
    logic            to_inc;
    logic            to_fire;
    logic            lu;

    hazard_lu_detect u_lu_detect (
        .id_rs_addr  (id_rs_addr_i),
        .id_rt_addr  (id_rt_addr_i),
        .id_uses_rs  (id_uses_rs_i),
        .id_uses_rt  (id_uses_rt_i),
        .ex_rd_addr  (ex_rd_addr_i),
        .ex_mem_read (ex_mem_read_i),
        .lu_hazard   (lu)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Outside RUN the EX stage holds only bubbles, so branch_taken_i is not consulted there.
    always_comb begin
        state_nxt     = state;
        pc_hold_o     = 1'b0;
        ifid_hold_o   = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        cgra_start_o  = 1'b0;
        to_clr        = 1'b0;
        to_inc        = 1'b0;
        to_fire       = 1'b0;
        case (state)
            ST_RUN: begin
                if (branch_taken_i) begin
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b1;
                end else if (lu) begin
                    pc_hold_o     = 1'b1;
                    ifid_hold_o   = 1'b1;
                    idex_bubble_o = 1'b1;
                end else if (id_cgra_op_i) begin
                    pc_hold_o     = 1'b1;
                    ifid_hold_o   = 1'b1;
                    idex_bubble_o = 1'b1;
                    state_nxt     = ST_CGRA_REQ;
                end
            end
            ST_CGRA_REQ: begin
                pc_hold_o     = 1'b1;
                ifid_hold_o   = 1'b1;
                idex_bubble_o = 1'b1;
                cgra_start_o  = 1'b1;
                if (cgra_ready_i) begin
                    to_clr    = 1'b1;
                    state_nxt = ST_CGRA_WAIT;
                end
            end
            ST_CGRA_WAIT: begin
                pc_hold_o     = 1'b1;
                ifid_hold_o   = 1'b1;
                idex_bubble_o = 1'b1;
                to_inc        = 1'b1;
                if (cgra_done_i) begin
                    state_nxt = ST_DONE;
                end else if (to_cnt == TO_LAST) begin
                    to_fire   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt         <= '0;
            cgra_timeout_o <= 1'b0;
        end else begin
            if (to_clr) begin
                to_cnt <= '0;
            end else if (to_inc) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_fire) begin
                cgra_timeout_o <= 1'b1;
            end
        end
    end

    // Stall counter saturates rather than wrapping; a clear in the same cycle wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_o <= '0;
        end else if (pc_hold_o && !(&stall_cnt_o)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    assign state_o = state;

endmodule
